wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the write-back stage plus the architectural register bank.
- Takes the registered MEM/WB fields and selects load data or ALU result. It writes the selected value into a 32-entry register file.
- Serves the two ID-stage read ports, with write-to-read bypass so an instruction in ID sees a value written in the same cycle.
- Exports the write-back value and destination for the forwarding unit, plus a retired-write counter for debug.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register index width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = read returns stored value only

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
MemWB_RegWrite_in  input  1  write-enable from MEM/WB register
MemWB_MemToReg_in  input  1  1 = write ReadData_in, 0 = write AluResult_in
ReadData_in  input  DATA_W  load data from MEM/WB register
AluResult_in  input  DATA_W  ALU result/address from MEM/WB register
WriteReg_in  input  ADDR_W  destination register index from MEM/WB register
ReadReg1_in  input  ADDR_W  ID-stage source register rs
ReadReg2_in  input  ADDR_W  ID-stage source register rt
ReadData1_out  output  DATA_W  value of ReadReg1_in
ReadData2_out  output  DATA_W  value of ReadReg2_in
WbData_out  output  DATA_W  selected write-back value (combinational)
WbWriteReg_out  output  ADDR_W  write-back destination (pass-through of WriteReg_in)
WbValid_out  output  1  1 when this cycle commits a write (RegWrite=1 and WriteReg!=0)
WbCount_out  output  32  number of committed writes since reset

Behaviour:
- Write-back mux: WbData_out = MemToReg ? ReadData_in : AluResult_in. This path is purely combinational.
- WbValid_out = MemWB_RegWrite_in & (WriteReg_in != 0) & rst_n.
- Commit: on posedge clk with WbValid_out=1, regs[WriteReg_in] <= WbData_out. The write has one-cycle latency to the stored array.
- Register 0 is hardwired to zero:
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0 regardless of bypass.
  - Index 0 does not count toward WbCount_out.
- Read ports are combinational and independent of each other.
- BYPASS=1:
  - If WbValid_out=1 and ReadRegN_in == WriteReg_in, then ReadDataN_out = WbData_out.
  - Otherwise ReadDataN_out = regs[ReadRegN_in].
  - Both ports may hit the bypass simultaneously.
- BYPASS=0: ReadDataN_out = regs[ReadRegN_in]. The new value is visible from the cycle after commit.
- Counter: WbCount_out increments by 1 on each commit edge. It wraps from 0xFFFFFFFF to 0 with no flag.
- Reset:
  - Asynchronous assertion of rst_n=0 immediately clears all regs and WbCount_out to 0.
  - WbValid_out is forced to 0, so ReadData outputs read 0.
  - Deassertion is sampled so that the first commit can occur on the first rising edge with rst_n=1.
  - A write pending in the cycle reset asserts is lost.
- Back-to-back writes to the same register on consecutive cycles: each commits in order, and the last one wins.
- Undefined or X on MemToReg while RegWrite=0 must not corrupt any register.

Test Plan:
- Reset, then read all 32 indices on both ports -> every ReadData = 0, WbCount_out = 0, WbValid_out = 0.
- RegWrite=1, MemToReg=0, AluResult=0x0000_00AA, WriteReg=5 for one edge; next cycle ReadReg1=5 -> ReadData1_out = 0x0000_00AA, WbCount_out = 1.
- BYPASS=1, same cycle: RegWrite=1, MemToReg=1, ReadData_in=0xDEAD_BEEF, WriteReg=9, ReadReg1=ReadReg2=9 -> both outputs 0xDEAD_BEEF before the edge. With BYPASS=0 they show the old value 0 until after the edge.
- RegWrite=1, WriteReg=0, AluResult=0xFFFF_FFFF -> WbValid_out=0, ReadData(0) stays 0, WbCount_out unchanged.
- Write 0x11 to r3 then 0x22 to r3 on consecutive edges; read r3 -> 0x22, WbCount_out = 2.
- Write 0x55 to r7, then assert rst_n=0 mid-cycle -> ReadData(r7) = 0 immediately, with no clock edge required, and WbCount_out = 0. After release, the first write commits normally.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register bank: selects load data or ALU result,
// commits it to a 32-entry register file, and serves two ID-stage read ports.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemWB_RegWrite_in,
  input  logic              MemWB_MemToReg_in,
  input  logic [DATA_W-1:0] ReadData_in,
  input  logic [DATA_W-1:0] AluResult_in,
  input  logic [ADDR_W-1:0] WriteReg_in,
  input  logic [ADDR_W-1:0] ReadReg1_in,
  input  logic [ADDR_W-1:0] ReadReg2_in,
  output logic [DATA_W-1:0] ReadData1_out,
  output logic [DATA_W-1:0] ReadData2_out,
  output logic [DATA_W-1:0] WbData_out,
  output logic [ADDR_W-1:0] WbWriteReg_out,
  output logic              WbValid_out,
  output logic [31:0]       WbCount_out
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [31:0]       r_wbCount;
  logic [DATA_W-1:0] w_wbData;
  logic              w_wbValid;

  // rst_n gates the commit so a write pending while reset is asserted is dropped
  assign w_wbData  = MemWB_MemToReg_in ? ReadData_in : AluResult_in;
  assign w_wbValid = MemWB_RegWrite_in & (WriteReg_in != '0) & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wbCount <= '0;
    end else if (w_wbValid) begin
      r_regs[WriteReg_in] <= w_wbData;
      r_wbCount           <= r_wbCount + 32'd1;
    end
  end

  always_comb begin
    ReadData1_out = r_regs[ReadReg1_in];
    if (ReadReg1_in == '0) begin
      ReadData1_out = '0;
    end else if (BYPASS && w_wbValid && (ReadReg1_in == WriteReg_in)) begin
      ReadData1_out = w_wbData;
    end
  end

  always_comb begin
    ReadData2_out = r_regs[ReadReg2_in];
    if (ReadReg2_in == '0) begin
      ReadData2_out = '0;
    end else if (BYPASS && w_wbValid && (ReadReg2_in == WriteReg_in)) begin
      ReadData2_out = w_wbData;
    end
  end

  assign WbData_out     = w_wbData;
  assign WbWriteReg_out = WriteReg_in;
  assign WbValid_out    = w_wbValid;
  assign WbCount_out    = r_wbCount;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: one bypassing and one non-bypassing instance share
// the same stimulus and are compared against a plain array model of the register file.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        regWrite;
  logic        memToReg;
  logic [31:0] readData;
  logic [31:0] aluResult;
  logic [4:0]  writeReg;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;

  logic [31:0] bRd1, bRd2, bWbData, bCount;
  logic [4:0]  bWbReg;
  logic        bValid;
  logic [31:0] nRd1, nRd2, nWbData, nCount;
  logic [4:0]  nWbReg;
  logic        nValid;

  int checks;
  int failures;

  logic [31:0] model [32];
  logic [31:0] modelCount;

  typedef struct {
    logic        we;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] expR1;
    logic [31:0] expR2;
    logic [31:0] expWb;
    logic        expValid;
    logic [31:0] expCount;
  } vec_t;

  vec_t vecs [8];

  wb_regfile #(.BYPASS(1'b1)) dutB (
    .clk(clk), .rst_n(rst_n),
    .MemWB_RegWrite_in(regWrite), .MemWB_MemToReg_in(memToReg),
    .ReadData_in(readData), .AluResult_in(aluResult), .WriteReg_in(writeReg),
    .ReadReg1_in(readReg1), .ReadReg2_in(readReg2),
    .ReadData1_out(bRd1), .ReadData2_out(bRd2), .WbData_out(bWbData),
    .WbWriteReg_out(bWbReg), .WbValid_out(bValid), .WbCount_out(bCount)
  );

  wb_regfile #(.BYPASS(1'b0)) dutN (
    .clk(clk), .rst_n(rst_n),
    .MemWB_RegWrite_in(regWrite), .MemWB_MemToReg_in(memToReg),
    .ReadData_in(readData), .AluResult_in(aluResult), .WriteReg_in(writeReg),
    .ReadReg1_in(readReg1), .ReadReg2_in(readReg2),
    .ReadData1_out(nRd1), .ReadData2_out(nRd2), .WbData_out(nWbData),
    .WbWriteReg_out(nWbReg), .WbValid_out(nValid), .WbCount_out(nCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic m2r, input logic [31:0] rd,
                               input logic [31:0] alu, input logic [4:0] wr,
                               input logic [4:0] r1, input logic [4:0] r2);
    regWrite  = we;
    memToReg  = m2r;
    readData  = rd;
    aluResult = alu;
    writeReg  = wr;
    readReg1  = r1;
    readReg2  = r2;
    #1;
  endtask

  function automatic logic modelValid();
    return (regWrite === 1'b1) && (writeReg != 5'd0) && (rst_n === 1'b1);
  endfunction

  function automatic logic [31:0] modelWb();
    return memToReg ? readData : aluResult;
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] idx, input logic byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && modelValid() && idx == writeReg) return modelWb();
    return model[idx];
  endfunction

  // Compares both instances against the model for the inputs currently applied
  task automatic checkAgainstModel(input string tag, input logic chkWb);
    checkOutput({tag, " rd1 bypass"}, bRd1, modelRead(readReg1, 1'b1));
    checkOutput({tag, " rd2 bypass"}, bRd2, modelRead(readReg2, 1'b1));
    checkOutput({tag, " rd1 nobypass"}, nRd1, modelRead(readReg1, 1'b0));
    checkOutput({tag, " rd2 nobypass"}, nRd2, modelRead(readReg2, 1'b0));
    checkOutput({tag, " valid"}, {31'd0, bValid}, {31'd0, modelValid()});
    checkOutput({tag, " valid nobypass"}, {31'd0, nValid}, {31'd0, modelValid()});
    checkOutput({tag, " wbreg"}, {27'd0, bWbReg}, {27'd0, writeReg});
    checkOutput({tag, " count"}, bCount, modelCount);
    checkOutput({tag, " count nobypass"}, nCount, modelCount);
    if (chkWb) begin
      checkOutput({tag, " wbdata"}, bWbData, modelWb());
      checkOutput({tag, " wbdata nobypass"}, nWbData, modelWb());
    end
  endtask

  task automatic commitEdge();
    if (modelValid()) begin
      model[writeReg] = modelWb();
      modelCount      = modelCount + 32'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    modelCount = 32'd0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clearModel();
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h1234_5678, 5'd4, 5'd4, 5'd0);

    // Write attempted while held in reset must be suppressed
    @(negedge clk);
    checkOutput("inreset valid", {31'd0, bValid}, 32'd0);
    checkOutput("inreset rd1", bRd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, i[4:0], 5'(31 - i));
      checkOutput("reset rd1", bRd1, 32'd0);
      checkOutput("reset rd2", bRd2, 32'd0);
      checkOutput("reset rd1 nobypass", nRd1, 32'd0);
      checkOutput("reset rd2 nobypass", nRd2, 32'd0);
    end
    checkOutput("reset count", bCount, 32'd0);
    checkOutput("reset valid", {31'd0, bValid}, 32'd0);

    //          we    m2r   rd             alu            wr    r1    r2    expR1          expR2          expWb          v     cnt
    vecs[0] = '{1'b1, 1'b0, 32'h0,         32'h0000_00AA, 5'd5, 5'd5, 5'd0, 32'h0000_00AA, 32'h0,         32'h0000_00AA, 1'b1, 32'd0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd5, 5'd5, 32'h0000_00AA, 32'h0000_00AA, 32'h0,         1'b0, 32'd1};
    vecs[2] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h123,       5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'd1};
    vecs[3] = '{1'b1, 1'b0, 32'h0,         32'hFFFF_FFFF, 5'd0, 5'd0, 5'd9, 32'h0,         32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'd2};
    vecs[4] = '{1'b1, 1'b0, 32'h0,         32'h11,        5'd3, 5'd3, 5'd5, 32'h11,        32'h0000_00AA, 32'h11,        1'b1, 32'd2};
    vecs[5] = '{1'b1, 1'b0, 32'h0,         32'h22,        5'd3, 5'd3, 5'd3, 32'h22,        32'h22,        32'h22,        1'b1, 32'd3};
    vecs[6] = '{1'b0, 1'b1, 32'h77,        32'h66,        5'd3, 5'd3, 5'd0, 32'h22,        32'h0,         32'h77,        1'b0, 32'd4};
    vecs[7] = '{1'b0, 1'b0, 32'h0,         32'h0,         5'd0, 5'd3, 5'd9, 32'h22,        32'hDEAD_BEEF, 32'h0,         1'b0, 32'd4};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].we, vecs[i].m2r, vecs[i].rd, vecs[i].alu, vecs[i].wr, vecs[i].r1, vecs[i].r2);
      checkOutput($sformatf("vec%0d rd1", i), bRd1, vecs[i].expR1);
      checkOutput($sformatf("vec%0d rd2", i), bRd2, vecs[i].expR2);
      checkOutput($sformatf("vec%0d wbdata", i), bWbData, vecs[i].expWb);
      checkOutput($sformatf("vec%0d valid", i), {31'd0, bValid}, {31'd0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d count", i), bCount, vecs[i].expCount);
      checkOutput($sformatf("vec%0d rd1 nobypass", i), nRd1, modelRead(readReg1, 1'b0));
      checkOutput($sformatf("vec%0d rd2 nobypass", i), nRd2, modelRead(readReg2, 1'b0));
      commitEdge();
    end

    // Unknown MemToReg with RegWrite low must leave every register untouched
    applyStimulus(1'b0, 1'bx, 32'hBAD0_BAD0, 32'hBAD1_BAD1, 5'd3, 5'd3, 5'd9);
    checkAgainstModel("xsel", 1'b0);
    commitEdge();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd5);
    checkOutput("xsel after r3", bRd1, 32'h22);
    checkOutput("xsel after r5", bRd2, 32'h0000_00AA);

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      logic [4:0] r1;
      logic [4:0] r2;
      wr = 5'($urandom_range(0, 12));
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, wr, r1, r2);
      checkAgainstModel("rand", 1'b1);
      commitEdge();
    end

    // Asynchronous reset mid-cycle wipes state without a clock edge
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h55, 5'd7, 5'd0, 5'd0);
    commitEdge();
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h99, 5'd7, 5'd7, 5'd7);
    checkOutput("prereset r7 nobypass", nRd1, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset r7", bRd1, 32'd0);
    checkOutput("async reset r7 nobypass", nRd1, 32'd0);
    checkOutput("async reset count", bCount, 32'd0);
    checkOutput("async reset valid", {31'd0, bValid}, 32'd0);
    clearModel();
    @(posedge clk);
    @(negedge clk);
    checkOutput("held reset r7", nRd2, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0, 32'h66, 5'd7, 5'd7, 5'd7);
    checkAgainstModel("postreset", 1'b1);
    commitEdge();
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd7, 5'd0);
    checkOutput("postreset r7", nRd1, 32'h66);
    checkOutput("postreset count", bCount, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
